// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - ID-stage hazard scoreboard with per-register Tnew countdown and MDU busy counter
module hazard_scoreboard #(
  parameter int NREG       = 32,
  parameter int AW         = 5,
  parameter int TW         = 2,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic          id_use_rs,
  input  logic          id_use_rt,
  input  logic [TW-1:0] id_tuse_rs,
  input  logic [TW-1:0] id_tuse_rt,
  input  logic          id_wr_en,
  input  logic [AW-1:0] id_wr_addr,
  input  logic [TW-1:0] id_tnew,
  input  logic          id_is_md,
  input  logic          id_md_div,
  input  logic          id_is_hilo,
  input  logic          flush,
  output logic          stall,
  output logic          issue,
  output logic          md_busy,
  output logic          pend_any
);

  // Entry 0 is never stored, so register 0 always reads back as ready.
  logic [TW-1:0] cnt [1:NREG-1];
  logic [7:0]    md_cnt;

  logic [TW-1:0] cnt_rs;
  logic [TW-1:0] cnt_rt;
  logic          haz_rs;
  logic          haz_rt;
  logic          haz_md;
  logic          alloc;

  always_comb begin
    cnt_rs   = '0;
    cnt_rt   = '0;
    pend_any = 1'b0;
    for (int i = 1; i < NREG; i++) begin
      if (id_rs == AW'(i)) cnt_rs = cnt[i];
      if (id_rt == AW'(i)) cnt_rt = cnt[i];
      pend_any = pend_any | (cnt[i] != '0);
    end
  end

  assign md_busy = (md_cnt != 8'd0);
  assign haz_rs  = id_use_rs & (id_rs != '0) & (cnt_rs > id_tuse_rs);
  assign haz_rt  = id_use_rt & (id_rt != '0) & (cnt_rt > id_tuse_rt);
  assign haz_md  = (id_is_md | id_is_hilo) & md_busy;
  assign stall   = id_valid & ~flush & (haz_rs | haz_rt | haz_md);
  assign issue   = id_valid & ~flush & ~stall;
  assign alloc   = issue & id_wr_en & (id_wr_addr != '0);

  // A fresh allocation wins over the drain of the same entry.
  always_ff @(posedge clk) begin
    for (int i = 1; i < NREG; i++) begin
      if (reset) begin
        cnt[i] <= '0;
      end else if (alloc && (id_wr_addr == AW'(i))) begin
        cnt[i] <= id_tnew;
      end else if (cnt[i] != '0) begin
        cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt <= 8'd0;
    end else if (issue && id_is_md) begin
      md_cnt <= id_md_div ? 8'(DIV_CYCLES) : 8'(MUL_CYCLES);
    end else if (md_cnt != 8'd0) begin
      md_cnt <= md_cnt - 8'd1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed and randomized checks of hazard_scoreboard against a behavioural model
module tb_hazard_scoreboard;

  localparam int NREG       = 32;
  localparam int AW         = 5;
  localparam int TW         = 2;
  localparam int MUL_CYCLES = 5;
  localparam int DIV_CYCLES = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          id_valid;
  logic [AW-1:0] id_rs;
  logic [AW-1:0] id_rt;
  logic          id_use_rs;
  logic          id_use_rt;
  logic [TW-1:0] id_tuse_rs;
  logic [TW-1:0] id_tuse_rt;
  logic          id_wr_en;
  logic [AW-1:0] id_wr_addr;
  logic [TW-1:0] id_tnew;
  logic          id_is_md;
  logic          id_md_div;
  logic          id_is_hilo;
  logic          flush;
  logic          stall;
  logic          issue;
  logic          md_busy;
  logic          pend_any;

  hazard_scoreboard #(
    .NREG(NREG), .AW(AW), .TW(TW), .MUL_CYCLES(MUL_CYCLES), .DIV_CYCLES(DIV_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_tuse_rs(id_tuse_rs),
    .id_tuse_rt(id_tuse_rt), .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr),
    .id_tnew(id_tnew), .id_is_md(id_is_md), .id_md_div(id_md_div),
    .id_is_hilo(id_is_hilo), .flush(flush), .stall(stall), .issue(issue),
    .md_busy(md_busy), .pend_any(pend_any)
  );

  always #5 clk = ~clk;

  // Model state: remaining cycles until each register's value is forwardable.
  int m_cnt [NREG];
  int m_md;

  int n_checks = 0;
  int n_fail   = 0;
  logic obs_stall, obs_issue, obs_md_busy, obs_pend;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    bit e_hrs, e_hrt, e_hmd, e_stall, e_issue, e_pend;
    @(negedge clk);
    e_hrs   = id_use_rs && (id_rs != 0) && (m_cnt[id_rs] > int'(id_tuse_rs));
    e_hrt   = id_use_rt && (id_rt != 0) && (m_cnt[id_rt] > int'(id_tuse_rt));
    e_hmd   = (id_is_md || id_is_hilo) && (m_md != 0);
    e_stall = id_valid && !flush && (e_hrs || e_hrt || e_hmd);
    e_issue = id_valid && !flush && !e_stall;
    e_pend  = 1'b0;
    for (int r = 1; r < NREG; r++) if (m_cnt[r] != 0) e_pend = 1'b1;
    obs_stall = stall; obs_issue = issue; obs_md_busy = md_busy; obs_pend = pend_any;
    if (!reset) begin
      check("stall", int'(stall), int'(e_stall));
      check("issue", int'(issue), int'(e_issue));
      check("md_busy", int'(md_busy), int'(m_md != 0));
      check("pend_any", int'(pend_any), int'(e_pend));
    end
    @(posedge clk);
    if (reset) begin
      for (int r = 0; r < NREG; r++) m_cnt[r] = 0;
      m_md = 0;
    end else begin
      for (int r = 1; r < NREG; r++) if (m_cnt[r] > 0) m_cnt[r]--;
      if (e_issue && id_wr_en && id_wr_addr != 0) m_cnt[id_wr_addr] = int'(id_tnew);
      if (e_issue && id_is_md) m_md = id_md_div ? DIV_CYCLES : MUL_CYCLES;
      else if (m_md > 0) m_md--;
    end
    #1;
  endtask

  task automatic set_idle();
    id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    id_tuse_rs = 0; id_tuse_rt = 0; id_wr_en = 0; id_wr_addr = 0; id_tnew = 0;
    id_is_md = 0; id_md_div = 0; id_is_hilo = 0; flush = 0;
  endtask

  // Present a reader/writer instruction: rs/rt with their Tuse, optional destination.
  task automatic set_ins(input int rs, input int ur, input int trs, input int rt, input int ut,
                         input int trt, input int we, input int wa, input int tn);
    set_idle();
    id_valid = 1; id_rs = AW'(rs); id_use_rs = ur[0]; id_tuse_rs = TW'(trs);
    id_rt = AW'(rt); id_use_rt = ut[0]; id_tuse_rt = TW'(trt);
    id_wr_en = we[0]; id_wr_addr = AW'(wa); id_tnew = TW'(tn);
  endtask

  task automatic set_md(input int is_md, input int div, input int hilo);
    set_idle();
    id_valid = 1; id_is_md = is_md[0]; id_md_div = div[0]; id_is_hilo = hilo[0];
  endtask

  // Hold the presented instruction until it issues; returns the stall cycles seen.
  task automatic run_insn(input string tag, output int n);
    bit done = 0;
    n = 0;
    for (int k = 0; k < 60 && !done; k++) begin
      cycle();
      if (obs_issue) done = 1;
      else if (obs_stall) n++;
    end
    if (!done) check({tag, "_timeout"}, 0, 1);
    set_idle();
  endtask

  task automatic idle(input int k);
    set_idle();
    for (int i = 0; i < k; i++) cycle();
  endtask

  initial begin
    int n;
    for (int r = 0; r < NREG; r++) m_cnt[r] = 0;
    m_md = 0;
    set_idle();
    reset = 1;
    cycle(); cycle();
    reset = 0;

    id_valid = 1;
    cycle();
    check("reset_issue", int'(obs_issue), 1);
    check("reset_stall", int'(obs_stall), 0);
    check("reset_md_busy", int'(obs_md_busy), 0);
    check("reset_pend", int'(obs_pend), 0);
    set_idle();

    set_ins(0, 0, 0, 0, 0, 0, 1, 8, 2); run_insn("lw8", n);
    set_ins(8, 1, 1, 0, 0, 0, 1, 9, 1); run_insn("load_use", n);
    check("load_use_stalls", n, 1);
    idle(3);

    set_ins(0, 0, 0, 0, 0, 0, 1, 3, 1); run_insn("addu3", n);
    set_ins(3, 1, 0, 5, 1, 0, 0, 0, 0); run_insn("alu_branch", n);
    check("alu_branch_stalls", n, 1);
    set_ins(0, 0, 0, 0, 0, 0, 1, 3, 2); run_insn("lw3", n);
    set_ins(3, 1, 0, 5, 1, 0, 0, 0, 0); run_insn("lw_branch", n);
    check("lw_branch_stalls", n, 2);
    idle(3);

    set_ins(0, 0, 0, 0, 0, 0, 1, 0, 2); run_insn("lw0", n);
    set_ins(0, 1, 1, 0, 0, 0, 0, 0, 0); run_insn("reg_zero", n);
    check("reg_zero_stalls", n, 0);
    check("reg_zero_pend", int'(obs_pend), 0);
    set_ins(0, 0, 0, 0, 0, 0, 1, 9, 2); run_insn("lw9", n);
    set_ins(9, 0, 0, 0, 0, 0, 1, 10, 1); run_insn("lui_no_use", n);
    check("no_use_stalls", n, 0);
    idle(3);

    set_md(1, 1, 0); run_insn("div", n);
    set_md(0, 0, 1); run_insn("mflo", n);
    check("mflo_after_div_stalls", n, DIV_CYCLES);
    set_md(1, 0, 0); run_insn("mult_a", n);
    set_md(1, 0, 0); run_insn("mult_b", n);
    check("mult_mult_stalls", n, MUL_CYCLES);
    idle(6);

    set_ins(0, 0, 0, 0, 0, 0, 1, 4, 2); run_insn("lw4", n);
    set_ins(0, 0, 0, 0, 0, 0, 1, 4, 1); run_insn("addu4", n);
    set_ins(4, 1, 0, 0, 0, 0, 0, 0, 0); run_insn("use4", n);
    check("overwrite_stalls", n, 1);
    idle(3);

    set_md(1, 0, 0); run_insn("mult_f", n);
    set_ins(0, 0, 0, 0, 0, 0, 1, 6, 2); flush = 1;
    cycle();
    check("flush_issue", int'(obs_issue), 0);
    check("flush_md_busy", int'(obs_md_busy), 1);
    set_ins(6, 1, 0, 0, 0, 0, 0, 0, 0); run_insn("use6", n);
    check("flush_no_alloc_stalls", n, 0);
    idle(6);

    set_md(1, 1, 0); run_insn("div_r", n);
    idle(3);
    set_ins(0, 0, 0, 0, 0, 0, 1, 7, 2); run_insn("lw7", n);
    check("pre_reset_md", m_md, 6);
    check("pre_reset_cnt7", m_cnt[7], 2);
    reset = 1; cycle(); reset = 0;
    set_ins(7, 1, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    check("post_reset_stall", int'(obs_stall), 0);
    check("post_reset_md_busy", int'(obs_md_busy), 0);
    check("post_reset_pend", int'(obs_pend), 0);
    set_idle();

    for (int k = 0; k < 3000; k++) begin
      id_valid   = ($urandom_range(0, 9) != 0);
      id_rs      = AW'($urandom_range(0, 7));
      id_rt      = AW'($urandom_range(0, 7));
      id_use_rs  = $urandom_range(0, 1) != 0;
      id_use_rt  = $urandom_range(0, 1) != 0;
      id_tuse_rs = TW'($urandom_range(0, 3));
      id_tuse_rt = TW'($urandom_range(0, 3));
      id_wr_en   = $urandom_range(0, 1) != 0;
      id_wr_addr = AW'($urandom_range(0, 7));
      id_tnew    = TW'($urandom_range(0, 3));
      id_is_md   = ($urandom_range(0, 9) == 0);
      id_md_div  = $urandom_range(0, 1) != 0;
      id_is_hilo = ($urandom_range(0, 7) == 0);
      flush      = ($urandom_range(0, 15) == 0);
      reset      = ($urandom_range(0, 199) == 0);
      cycle();
    end
    reset = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
